// File: rtl/pipeline_scoreboard.sv
// In-order pipeline hazard scoreboard: tracks in-flight writers and decides stall / operand forwarding.
// Define SCOREBOARD_FORWARD_EN for the forwarding policy; otherwise every RAW hazard stalls.
module pipeline_scoreboard #(
  parameter int NUM_REGS = 32,
  parameter int DEPTH    = 2,
  parameter int REG_W    = $clog2(NUM_REGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             issue_valid,
  input  logic [REG_W-1:0] issue_src1,
  input  logic [REG_W-1:0] issue_src2,
  input  logic [REG_W-1:0] issue_dest,
  input  logic             issue_wb_en,
  input  logic             issue_is_load,
  input  logic             flush,
  output logic             stall,
  output logic [3:0]       fwd_sel1,
  output logic [3:0]       fwd_sel2,
  output logic [15:0]      stall_cnt
);

  logic [DEPTH:1]   ent_valid;
  logic [DEPTH:1]   ent_wb_en;
  logic [DEPTH:1]   ent_is_load;
  logic [REG_W-1:0] ent_dest [1:DEPTH];

  logic [DEPTH:1] match1;
  logic [DEPTH:1] match2;
  logic           active;
  logic           hazard;
  logic           issue_accept;
  logic           unused_is_load;

  // Register 0 never creates a dependency, whatever is in flight for it.
  always_comb begin
    match1 = '0;
    match2 = '0;
    for (int k = 1; k <= DEPTH; k++) begin
      match1[k] = ent_valid[k] && ent_wb_en[k] && (ent_dest[k] == issue_src1) && (issue_src1 != '0);
      match2[k] = ent_valid[k] && ent_wb_en[k] && (ent_dest[k] == issue_src2) && (issue_src2 != '0);
    end
  end

  assign active = rst && issue_valid && !flush;

`ifdef SCOREBOARD_FORWARD_EN
  function automatic logic [3:0] youngest(input logic [DEPTH:1] m);
    logic [3:0] sel;
    sel = '0;
    for (int k = DEPTH; k >= 1; k--) begin
      if (m[k]) sel = 4'(k);
    end
    return sel;
  endfunction

  // Only a load still in stage 1 cannot be forwarded; a stalled operand is not consumed, so its select is 0.
  always_comb begin
    hazard   = (match1[1] || match2[1]) && ent_is_load[1];
    stall    = active && hazard;
    fwd_sel1 = '0;
    fwd_sel2 = '0;
    if (active && !hazard) begin
      fwd_sel1 = youngest(match1);
      fwd_sel2 = youngest(match2);
    end
  end
`else
  always_comb begin
    hazard = (|match1) || (|match2);
    stall  = active && hazard;
  end

  assign fwd_sel1 = '0;
  assign fwd_sel2 = '0;
`endif

  assign issue_accept   = active && !stall;
  assign unused_is_load = ^ent_is_load;

  // Bubbles carry zeroed fields so a stale dest can never be mistaken for a producer.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ent_valid   <= '0;
      ent_wb_en   <= '0;
      ent_is_load <= '0;
      for (int k = 1; k <= DEPTH; k++) ent_dest[k] <= '0;
    end else begin
      ent_valid[1]   <= issue_accept;
      ent_wb_en[1]   <= issue_accept && issue_wb_en;
      ent_is_load[1] <= issue_accept && issue_is_load;
      ent_dest[1]    <= issue_accept ? issue_dest : '0;
      for (int k = 2; k <= DEPTH; k++) begin
        ent_valid[k]   <= ent_valid[k-1];
        ent_wb_en[k]   <= ent_wb_en[k-1];
        ent_is_load[k] <= ent_is_load[k-1];
        ent_dest[k]    <= ent_dest[k-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_pipeline_scoreboard.sv
// Directed scoreboard bench for pipeline_scoreboard; expectations follow SCOREBOARD_FORWARD_EN if defined.
module tb_pipeline_scoreboard;

`ifdef SCOREBOARD_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b0;
  logic       issue_valid = 1'b0;
  logic [4:0] issue_src1 = '0;
  logic [4:0] issue_src2 = '0;
  logic [4:0] issue_dest = '0;
  logic       issue_wb_en = 1'b0;
  logic       issue_is_load = 1'b0;
  logic       flush = 1'b0;
  logic       stall;
  logic [3:0] fwd_sel1;
  logic [3:0] fwd_sel2;
  logic [15:0] stall_cnt;

  logic       rst_b = 1'b0;
  logic       valid_b = 1'b0;
  logic [4:0] src1_b = '0;
  logic [4:0] dest_b = '0;
  logic       stall_b;
  logic [3:0] fwd1_b;
  logic [3:0] fwd2_b;
  logic [15:0] cnt_b;

  pipeline_scoreboard #(.NUM_REGS(32), .DEPTH(2), .REG_W(5)) dut (
    .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_src1(issue_src1),
    .issue_src2(issue_src2), .issue_dest(issue_dest), .issue_wb_en(issue_wb_en),
    .issue_is_load(issue_is_load), .flush(flush), .stall(stall),
    .fwd_sel1(fwd_sel1), .fwd_sel2(fwd_sel2), .stall_cnt(stall_cnt)
  );

  // Deep instance used for counter saturation, where long stall runs are possible.
  pipeline_scoreboard #(.NUM_REGS(32), .DEPTH(8), .REG_W(5)) dut_deep (
    .clk(clk), .rst(rst_b), .issue_valid(valid_b), .issue_src1(src1_b),
    .issue_src2(5'd0), .issue_dest(dest_b), .issue_wb_en(1'b1),
    .issue_is_load(1'b0), .flush(1'b0), .stall(stall_b),
    .fwd_sel1(fwd1_b), .fwd_sel2(fwd2_b), .stall_cnt(cnt_b)
  );

  typedef struct {
    logic       stall;
    logic [3:0] f1;
    logic [3:0] f2;
    string      tag;
  } exp_t;

  exp_t sbq[$];
  int checks = 0;
  int errors = 0;

  task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input string tag, input logic r, input logic v,
                               input logic [4:0] s1, input logic [4:0] s2, input logic [4:0] d,
                               input logic wb, input logic ld, input logic fl,
                               input logic es, input logic [3:0] e1, input logic [3:0] e2);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r;
    issue_valid = v;
    issue_src1 = s1;
    issue_src2 = s2;
    issue_dest = d;
    issue_wb_en = wb;
    issue_is_load = ld;
    flush = fl;
    e.stall = es;
    e.f1 = e1;
    e.f2 = e2;
    e.tag = tag;
    sbq.push_back(e);
  endtask

  task automatic checkOutput();
    exp_t e;
    @(negedge clk);
    e = sbq.pop_front();
    checkValue({e.tag, "_stall"}, {31'd0, stall}, {31'd0, e.stall});
    checkValue({e.tag, "_fwd1"}, {28'd0, fwd_sel1}, {28'd0, e.f1});
    checkValue({e.tag, "_fwd2"}, {28'd0, fwd_sel2}, {28'd0, e.f2});
  endtask

  task automatic step(input string tag, input logic r, input logic v,
                      input logic [4:0] s1, input logic [4:0] s2, input logic [4:0] d,
                      input logic wb, input logic ld, input logic fl,
                      input logic es, input logic [3:0] e1, input logic [3:0] e2);
    applyStimulus(tag, r, v, s1, s2, d, wb, ld, fl, es, e1, e2);
    checkOutput();
  endtask

  task automatic idle(input string tag);
    step(tag, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic driveDeep(input logic r, input logic v, input logic [4:0] s1, input logic [4:0] d);
    @(posedge clk);
    #1;
    rst_b = r;
    valid_b = v;
    src1_b = s1;
    dest_b = d;
  endtask

  initial begin
    step("rst_hold", 0, 1, 3, 3, 3, 1, 1, 0, 0, 0, 0);
    step("rst_idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkValue("cnt_reset", {16'd0, stall_cnt}, 32'd0);

`ifdef SCOREBOARD_FORWARD_EN
    step("a1_prod_r3", 1, 1, 0, 0, 3, 1, 0, 0, 0, 0, 0);
    step("a2_r5_r3r3", 1, 1, 3, 3, 5, 1, 0, 0, 0, 1, 1);
    step("a3_r6_r0r3", 1, 1, 0, 3, 6, 1, 0, 0, 0, 0, 2);
    step("a4_r7_r5r6", 1, 1, 5, 6, 7, 1, 0, 0, 0, 2, 1);
    idle("a5_idle");
    idle("a6_idle");
    step("l1_load_r7", 1, 1, 0, 0, 7, 1, 1, 0, 0, 0, 0);
    step("l2_use_r7", 1, 1, 7, 0, 10, 1, 0, 0, 1, 0, 0);
    step("l3_use_r7", 1, 1, 7, 0, 10, 1, 0, 0, 0, 2, 0);
    checkValue("cnt_load", {16'd0, stall_cnt}, 32'd1);
    idle("l4_idle");
    idle("l5_idle");
`else
    step("a1_prod_r3", 1, 1, 0, 0, 3, 1, 0, 0, 0, 0, 0);
    step("a2_r4_r3", 1, 1, 3, 0, 4, 1, 0, 0, 1, 0, 0);
    step("a3_r4_r3", 1, 1, 3, 0, 4, 1, 0, 0, 1, 0, 0);
    step("a4_r4_issue", 1, 1, 3, 0, 4, 1, 0, 0, 0, 0, 0);
    checkValue("cnt_a", {16'd0, stall_cnt}, 32'd2);
    idle("a5_idle");
    idle("a6_idle");
`endif

    step("m1_r8", 1, 1, 0, 0, 8, 1, 0, 0, 0, 0, 0);
    step("m2_r8", 1, 1, 0, 0, 8, 1, 0, 0, 0, 0, 0);
    step("m3_r9_r8r8", 1, 1, 8, 8, 9, 1, 0, 0, !FWD, FWD ? 4'd1 : 4'd0, FWD ? 4'd1 : 4'd0);
    idle("m4_idle");
    idle("m5_idle");

    step("b1_load_r0", 1, 1, 0, 0, 0, 1, 1, 0, 0, 0, 0);
    step("b2_use_r0", 1, 1, 0, 0, 11, 1, 0, 0, 0, 0, 0);
    idle("b3_idle");
    idle("b4_idle");

    step("c1_nowb_r6", 1, 1, 0, 0, 6, 0, 1, 0, 0, 0, 0);
    step("c2_use_r6", 1, 1, 6, 6, 12, 1, 0, 0, 0, 0, 0);
    idle("c3_idle");
    idle("c4_idle");

    step("d1_self_r8", 1, 1, 8, 0, 8, 1, 0, 0, 0, 0, 0);
    step("d2_src2_r8", 1, 1, 0, 8, 13, 1, 0, 0, !FWD, 0, FWD ? 4'd1 : 4'd0);
    step("d3_novalid", 1, 0, 8, 8, 13, 1, 0, 0, 0, 0, 0);
    idle("d4_idle");

    step("e1_load_r9", 1, 1, 0, 0, 9, 1, 1, 0, 0, 0, 0);
    step("e2_flush", 1, 1, 9, 0, 10, 1, 0, 1, 0, 0, 0);
    step("e3_use_r10", 1, 1, 10, 0, 14, 1, 0, 0, 0, 0, 0);
    idle("e4_idle");
    idle("e5_idle");

    step("g1_r12", 1, 1, 0, 0, 12, 1, 0, 0, 0, 0, 0);
    step("g2_load_r13", 1, 1, 0, 0, 13, 1, 1, 0, 0, 0, 0);
    checkValue("cnt_pre_rst", {16'd0, stall_cnt}, FWD ? 32'd1 : 32'd4);
    step("g3_rst_hazard", 0, 1, 13, 12, 17, 1, 0, 0, 0, 0, 0);
    step("g4_after_rst", 1, 1, 13, 0, 18, 1, 0, 0, 0, 0, 0);
    checkValue("cnt_post_rst", {16'd0, stall_cnt}, 32'd0);

`ifndef SCOREBOARD_FORWARD_EN
    driveDeep(0, 0, 0, 0);
    driveDeep(0, 0, 0, 0);
    for (int r = 0; r < 8200; r++) begin
      driveDeep(1, 1, 0, 1);
      if (r == 1) begin
        @(negedge clk);
        checkValue("deep_issue_stall", {31'd0, stall_b}, 32'd0);
      end
      for (int c = 0; c < 8; c++) driveDeep(1, 1, 1, 2);
      if (r == 0 || r == 8190 || r == 8191 || r == 8199) begin
        @(negedge clk);
        checkValue($sformatf("deep_stall_r%0d", r), {31'd0, stall_b}, 32'd1);
        checkValue($sformatf("deep_cnt_r%0d", r), {16'd0, cnt_b},
                   (8 * r + 7 > 65535) ? 32'hFFFF : 32'(8 * r + 7));
      end
    end
    driveDeep(1, 1, 0, 1);
    driveDeep(1, 1, 1, 2);
    @(negedge clk);
    checkValue("deep_sat_stall", {31'd0, stall_b}, 32'd1);
    checkValue("deep_sat_cnt", {16'd0, cnt_b}, 32'hFFFF);
    driveDeep(0, 1, 1, 2);
    @(negedge clk);
    checkValue("deep_rst_stall", {31'd0, stall_b}, 32'd0);
    driveDeep(1, 1, 1, 2);
    @(negedge clk);
    checkValue("deep_post_stall", {31'd0, stall_b}, 32'd0);
    checkValue("deep_post_cnt", {16'd0, cnt_b}, 32'd0);
    checkValue("deep_post_fwd", {24'd0, fwd1_b, fwd2_b}, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
